// File: rtl/tx_seq_tracker.sv
// Per-port cell tracker on the shared-memory read bus: reassembles up to CTX_NUB
// interleaved packets, checks sequence order, and aborts contexts that stall.
module tx_seq_tracker #(
  parameter int PORT_ID  = 0,
  parameter int PORT_NUB = 16,
  parameter int LEN_MAX  = 256,
  parameter int CTX_NUB  = 2,
  parameter int DATA_W   = 64,
  parameter int TIMEOUT  = 1023,
  parameter int SEL_W    = $clog2(PORT_NUB),
  parameter int LEN_W    = $clog2(LEN_MAX + 1),
  parameter int CTX_W    = (CTX_NUB > 1) ? $clog2(CTX_NUB) : 1,
  parameter int TMR_W    = $clog2(TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_in,
  input  logic               rd_en_in,
  input  logic [SEL_W-1:0]   tx_in,
  input  logic [CTX_W-1:0]   ctx_in,
  input  logic [LEN_W-1:0]   seq_in,
  input  logic [LEN_W-1:0]   length_in,
  input  logic [DATA_W-1:0]  data_in,
  output logic               valid_out,
  output logic               sop_out,
  output logic               eop_out,
  output logic [CTX_W-1:0]   ctx_out,
  output logic [DATA_W-1:0]  data_out,
  output logic               drop_out,
  output logic               timeout_out,
  output logic [CTX_NUB-1:0] busy_out,
  output logic [15:0]        err_cnt_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DROP = 2'd2} ctx_state_e;

  ctx_state_e       state_q  [CTX_NUB];
  ctx_state_e       state_d  [CTX_NUB];
  logic [LEN_W-1:0] exp_q    [CTX_NUB];
  logic [LEN_W-1:0] exp_d    [CTX_NUB];
  logic [LEN_W-1:0] remain_q [CTX_NUB];
  logic [LEN_W-1:0] remain_d [CTX_NUB];
  logic [TMR_W-1:0] timer_q  [CTX_NUB];
  logic [TMR_W-1:0] timer_d  [CTX_NUB];

  logic               hit, ctx_ok, start_ok;
  logic [CTX_NUB-1:0] hit_vec;
  logic               valid_d, sop_d, eop_d, drop_d, timeout_d;
  logic [CTX_W-1:0]   ctx_d;
  logic [DATA_W-1:0]  data_d;
  logic [15:0]        tmo_cnt;
  logic [16:0]        err_sum;
  logic [15:0]        err_d;

  assign hit      = rd_en_in && (tx_in == SEL_W'(PORT_ID));
  assign ctx_ok   = int'(ctx_in) < CTX_NUB;
  assign start_ok = (seq_in == '0) && (length_in != '0) && (length_in <= LEN_W'(LEN_MAX));

  always_comb begin
    for (int c = 0; c < CTX_NUB; c++) begin
      hit_vec[c] = hit && ctx_ok && (int'(ctx_in) == c);
      busy_out[c] = (state_q[c] != IDLE);
    end
  end

  // State register: per-context FSM plus the registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CTX_NUB; c++) begin
        state_q[c]  <= IDLE;
        exp_q[c]    <= '0;
        remain_q[c] <= '0;
        timer_q[c]  <= '0;
      end
      valid_out   <= 1'b0;
      sop_out     <= 1'b0;
      eop_out     <= 1'b0;
      ctx_out     <= '0;
      data_out    <= '0;
      drop_out    <= 1'b0;
      timeout_out <= 1'b0;
      err_cnt_out <= '0;
    end else begin
      for (int c = 0; c < CTX_NUB; c++) begin
        state_q[c]  <= state_d[c];
        exp_q[c]    <= exp_d[c];
        remain_q[c] <= remain_d[c];
        timer_q[c]  <= timer_d[c];
      end
      valid_out   <= valid_d;
      sop_out     <= sop_d;
      eop_out     <= eop_d;
      ctx_out     <= ctx_d;
      data_out    <= data_d;
      drop_out    <= drop_d;
      timeout_out <= timeout_d;
      err_cnt_out <= err_d;
    end
  end

  // Next-state logic; a hit always clears the timer, so it beats a same-cycle expiry.
  always_comb begin
    for (int c = 0; c < CTX_NUB; c++) begin
      state_d[c]  = state_q[c];
      exp_d[c]    = exp_q[c];
      remain_d[c] = remain_q[c];
      timer_d[c]  = timer_q[c];
      if (flush_in) begin
        state_d[c]  = IDLE;
        exp_d[c]    = '0;
        remain_d[c] = '0;
        timer_d[c]  = '0;
      end else if (hit_vec[c]) begin
        timer_d[c] = '0;
        if (state_q[c] == RECV) begin
          if (seq_in == exp_q[c]) begin
            exp_d[c] = exp_q[c] + LEN_W'(1);
            if (remain_q[c] == LEN_W'(1)) state_d[c] = IDLE;
            else remain_d[c] = remain_q[c] - LEN_W'(1);
          end else begin
            state_d[c] = DROP;
          end
        end else if (start_ok && (length_in != LEN_W'(1))) begin
          state_d[c]  = RECV;
          exp_d[c]    = LEN_W'(1);
          remain_d[c] = length_in - LEN_W'(1);
        end else if (start_ok) begin
          state_d[c] = IDLE;
        end
      end else if (state_q[c] != IDLE) begin
        if (timer_q[c] == TMR_W'(TIMEOUT - 1)) begin
          state_d[c] = IDLE;
          timer_d[c] = '0;
        end else begin
          timer_d[c] = timer_q[c] + TMR_W'(1);
        end
      end
    end
  end

  // Output logic: values presented on the outputs after the next edge.
  always_comb begin
    valid_d   = 1'b0;
    sop_d     = 1'b0;
    eop_d     = 1'b0;
    drop_d    = 1'b0;
    timeout_d = 1'b0;
    tmo_cnt   = '0;
    if (!flush_in) begin
      if (hit && !ctx_ok) drop_d = 1'b1;
      for (int c = 0; c < CTX_NUB; c++) begin
        case (state_q[c])
          IDLE: if (hit_vec[c]) begin
            if (start_ok) begin
              valid_d = 1'b1;
              sop_d   = 1'b1;
              eop_d   = (length_in == LEN_W'(1));
            end else begin
              drop_d = 1'b1;
            end
          end
          RECV: if (hit_vec[c]) begin
            if (seq_in == exp_q[c]) begin
              valid_d = 1'b1;
              eop_d   = (remain_q[c] == LEN_W'(1));
            end else begin
              drop_d = 1'b1;
            end
          end else if (timer_q[c] == TMR_W'(TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            tmo_cnt   = tmo_cnt + 16'd1;
          end
          DROP: if (hit_vec[c] && start_ok) begin
            valid_d = 1'b1;
            sop_d   = 1'b1;
            eop_d   = (length_in == LEN_W'(1));
          end
          default: ;
        endcase
      end
    end
    ctx_d   = valid_d ? ctx_in : '0;
    data_d  = valid_d ? data_in : '0;
    err_sum = {1'b0, err_cnt_out} + 17'(drop_d) + {1'b0, tmo_cnt};
    err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

endmodule

// File: tb/tb_tx_seq_tracker.sv
// Directed vector bench for tx_seq_tracker: one table row per clock cycle,
// plus a hand-written asynchronous-reset sequence.
module tb_tx_seq_tracker;
  localparam int P     = 5;
  localparam int DW    = 16;
  localparam int TMO   = 8;
  localparam int SEL_W = 4;
  localparam int LEN_W = 9;
  localparam int CTX_W = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush_in = 1'b0;
  logic             rd_en_in = 1'b0;
  logic [SEL_W-1:0] tx_in = '0;
  logic [CTX_W-1:0] ctx_in = '0;
  logic [LEN_W-1:0] seq_in = '0;
  logic [LEN_W-1:0] length_in = '0;
  logic [DW-1:0]    data_in = '0;
  logic             valid_out, sop_out, eop_out, drop_out, timeout_out;
  logic [CTX_W-1:0] ctx_out;
  logic [DW-1:0]    data_out;
  logic [1:0]       busy_out;
  logic [15:0]      err_cnt_out;

  always #5 clk = ~clk;

  tx_seq_tracker #(
    .PORT_ID(P), .PORT_NUB(16), .LEN_MAX(256), .CTX_NUB(2), .DATA_W(DW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush_in(flush_in), .rd_en_in(rd_en_in),
    .tx_in(tx_in), .ctx_in(ctx_in), .seq_in(seq_in), .length_in(length_in),
    .data_in(data_in), .valid_out(valid_out), .sop_out(sop_out), .eop_out(eop_out),
    .ctx_out(ctx_out), .data_out(data_out), .drop_out(drop_out),
    .timeout_out(timeout_out), .busy_out(busy_out), .err_cnt_out(err_cnt_out)
  );

  typedef struct {
    logic        rd;
    logic [3:0]  tx;
    logic        c;
    logic [8:0]  seq;
    logic [8:0]  len;
    logic        fl;
    logic [15:0] d;
    logic        v, s, e, dr, to;
    logic [1:0]  busy;
    logic [15:0] err;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rd, input int tx, input int c, input int seq, input int len,
                     input logic fl, input logic v, input logic s, input logic e,
                     input logic dr, input logic to, input int busy, input int err);
    vec_t t;
    t.rd = rd; t.tx = 4'(tx); t.c = 1'(c); t.seq = 9'(seq); t.len = 9'(len); t.fl = fl;
    t.d = 16'(16'hC000 + vecs.size());
    t.v = v; t.s = s; t.e = e; t.dr = dr; t.to = to; t.busy = 2'(busy); t.err = 16'(err);
    vecs.push_back(t);
  endtask

  // Cell to this port: ctx, seq, length, then expected valid/sop/eop/drop/timeout/busy/err.
  task automatic hitv(input int c, input int seq, input int len, input logic v, input logic s,
                      input logic e, input logic dr, input logic to, input int busy, input int err);
    add(1'b1, P, c, seq, len, 1'b0, v, s, e, dr, to, busy, err);
  endtask

  task automatic idle(input int n, input int busy, input int err);
    for (int i = 0; i < n; i++) add(1'b0, P, 0, 0, 0, 1'b0, 0, 0, 0, 0, 0, busy, err);
  endtask

  task automatic drive(input vec_t t);
    @(negedge clk);
    rd_en_in = t.rd; tx_in = t.tx; ctx_in = t.c; seq_in = t.seq;
    length_in = t.len; flush_in = t.fl; data_in = t.d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, -1, 32'(valid_out), 0);
    chk({tag, "_sop"}, -1, 32'(sop_out), 0);
    chk({tag, "_eop"}, -1, 32'(eop_out), 0);
    chk({tag, "_drop"}, -1, 32'(drop_out), 0);
    chk({tag, "_timeout"}, -1, 32'(timeout_out), 0);
    chk({tag, "_busy"}, -1, 32'(busy_out), 0);
    chk({tag, "_err"}, -1, 32'(err_cnt_out), 0);
    chk({tag, "_data"}, -1, 32'(data_out), 0);
  endtask

  initial begin
    // single packet, ctx0 length 4
    hitv(0, 0, 4, 1, 1, 0, 0, 0, 1, 0);
    hitv(0, 1, 0, 1, 0, 0, 0, 0, 1, 0);
    hitv(0, 2, 0, 1, 0, 0, 0, 0, 1, 0);
    hitv(0, 3, 0, 1, 0, 1, 0, 0, 0, 0);
    // interleave ctx0 length 3 / ctx1 length 2
    hitv(0, 0, 3, 1, 1, 0, 0, 0, 1, 0);
    hitv(1, 0, 2, 1, 1, 0, 0, 0, 3, 0);
    hitv(0, 1, 0, 1, 0, 0, 0, 0, 3, 0);
    hitv(1, 1, 0, 1, 0, 1, 0, 0, 1, 0);
    hitv(0, 2, 0, 1, 0, 1, 0, 0, 0, 0);
    // out of order then restart from DROP
    hitv(0, 0, 5, 1, 1, 0, 0, 0, 1, 0);
    hitv(0, 1, 0, 1, 0, 0, 0, 0, 1, 0);
    hitv(0, 3, 0, 0, 0, 0, 1, 0, 1, 1);
    hitv(0, 4, 0, 0, 0, 0, 0, 0, 1, 1);
    hitv(0, 0, 1, 1, 1, 1, 0, 0, 0, 1);
    // filtering and length edges
    add(1'b1, 3, 0, 0, 4, 1'b0, 0, 0, 0, 0, 0, 0, 1);
    hitv(0, 0, 0, 0, 0, 0, 1, 0, 0, 2);
    hitv(1, 0, 1, 1, 1, 1, 0, 0, 0, 2);
    hitv(0, 2, 4, 0, 0, 0, 1, 0, 0, 3);
    hitv(0, 0, 300, 0, 0, 0, 1, 0, 0, 4);
    add(1'b0, P, 0, 0, 3, 1'b0, 0, 0, 0, 0, 0, 0, 4);
    // timeout on ctx1 then orphan cell
    hitv(1, 0, 3, 1, 1, 0, 0, 0, 2, 4);
    idle(TMO - 1, 2, 4);
    add(1'b0, P, 0, 0, 0, 1'b0, 0, 0, 0, 0, 1, 0, 5);
    hitv(1, 1, 0, 0, 0, 0, 1, 0, 0, 6);
    // hit on the expiry cycle wins, then a real expiry
    hitv(0, 0, 3, 1, 1, 0, 0, 0, 1, 6);
    idle(TMO - 1, 1, 6);
    hitv(0, 1, 0, 1, 0, 0, 0, 0, 1, 6);
    idle(TMO - 1, 1, 6);
    add(1'b0, P, 0, 0, 0, 1'b0, 0, 0, 0, 0, 1, 0, 7);
    // drop on ctx0 and timeout on ctx1 in the same cycle
    hitv(1, 0, 2, 1, 1, 0, 0, 0, 2, 7);
    idle(TMO - 1, 2, 7);
    hitv(0, 3, 0, 0, 0, 0, 1, 1, 0, 9);
    // DROP state expires silently
    hitv(0, 0, 4, 1, 1, 0, 0, 0, 1, 9);
    hitv(0, 2, 0, 0, 0, 0, 1, 0, 1, 10);
    idle(TMO - 1, 1, 10);
    idle(1, 0, 10);
    // DROP restart goes straight to RECV
    hitv(0, 0, 3, 1, 1, 0, 0, 0, 1, 10);
    hitv(0, 2, 0, 0, 0, 0, 1, 0, 1, 11);
    hitv(0, 0, 2, 1, 1, 0, 0, 0, 1, 11);
    hitv(0, 1, 0, 1, 0, 1, 0, 0, 0, 11);
    // flush with a same-cycle hit, err count survives
    hitv(1, 0, 4, 1, 1, 0, 0, 0, 2, 11);
    add(1'b1, P, 1, 1, 0, 1'b1, 0, 0, 0, 0, 0, 0, 11);
    hitv(1, 1, 0, 0, 0, 0, 1, 0, 0, 12);

    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      chk("valid", i, 32'(valid_out), 32'(vecs[i].v));
      chk("sop", i, 32'(sop_out), 32'(vecs[i].s));
      chk("eop", i, 32'(eop_out), 32'(vecs[i].e));
      chk("drop", i, 32'(drop_out), 32'(vecs[i].dr));
      chk("timeout", i, 32'(timeout_out), 32'(vecs[i].to));
      chk("busy", i, 32'(busy_out), 32'(vecs[i].busy));
      chk("err_cnt", i, 32'(err_cnt_out), 32'(vecs[i].err));
      if (vecs[i].v) begin
        chk("ctx", i, 32'(ctx_out), 32'(vecs[i].c));
        chk("data", i, 32'(data_out), 32'(vecs[i].d));
      end
    end

    // async reset mid-packet clears outputs and err count without a clock edge
    @(negedge clk);
    rd_en_in = 1'b1; tx_in = 4'(P); ctx_in = 1'b0; seq_in = 9'd0; length_in = 9'd4;
    flush_in = 1'b0; data_in = 16'h1234;
    @(posedge clk);
    #1;
    chk("pre_rst_valid", -1, 32'(valid_out), 1);
    chk("pre_rst_data", -1, 32'(data_out), 32'h1234);
    chk("pre_rst_err", -1, 32'(err_cnt_out), 12);
    seq_in = 9'd1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    rd_en_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_en_in = 1'b1; seq_in = 9'd1; length_in = 9'd0;
    @(posedge clk);
    #1;
    chk("post_rst_orphan_drop", -1, 32'(drop_out), 1);
    chk("post_rst_valid", -1, 32'(valid_out), 0);
    chk("post_rst_err", -1, 32'(err_cnt_out), 1);
    @(negedge clk);
    rd_en_in = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_seq_tracker.md
Name: tx_seq_tracker

Overview:
- Per-output-port cell tracker on the shared-memory read side.
- Monitors the shared read bus, accepts cells addressed to this port, and tracks up to CTX_NUB concurrently interleaved packets.
- Each context independently checks the sequence index and counts down the remaining length.
- Emits registered valid/sop/eop/data to the port TX logic; flags out-of-order and orphan cells, and times out stalled packets.

Parameters:
PORT_ID, 0, index of the output port this instance serves
PORT_NUB, 16, total ports; SEL_W = $clog2(PORT_NUB)
LEN_MAX, 256, max packet length in cells; LEN_W = $clog2(LEN_MAX+1)
CTX_NUB, 2, concurrent packet contexts; CTX_W = max(1, $clog2(CTX_NUB))
DATA_W, 64, cell data width
TIMEOUT, 1023, idle cycles before an open context is aborted; TMR_W = $clog2(TIMEOUT+1)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
flush_in  in  1  sync abort of all contexts
rd_en_in  in  1  shared bus cell strobe
tx_in  in  SEL_W  destination port of bus cell
ctx_in  in  CTX_W  context slot of bus cell
seq_in  in  LEN_W  cell index within packet, 0 = first
length_in  in  LEN_W  packet length in cells, meaningful only when seq_in==0
data_in  in  DATA_W  cell payload
valid_out  out  1  accepted cell present
sop_out  out  1  first cell of packet
eop_out  out  1  last cell of packet
ctx_out  out  CTX_W  context of output cell
data_out  out  DATA_W  payload of output cell
drop_out  out  1  cell or packet discarded (pulse)
timeout_out  out  1  context aborted by timer (pulse)
busy_out  out  CTX_NUB  per-context state != IDLE
err_cnt_out  out  16  saturating count of drop and timeout events

Behaviour:
- Reset (async) and flush_in (sync):
  - All contexts go to IDLE; timers and counts clear.
  - All outputs go to 0, including err_cnt_out on reset only; flush does not clear err_cnt_out.
- Cell hit: rd_en_in && tx_in==PORT_ID. At most one hit per cycle; it affects only context ctx_in. If ctx_in>=CTX_NUB, the cell is dropped.
- Outputs are registered, 1-cycle latency from hit to valid_out/sop/eop/data/ctx. drop_out and timeout_out are also registered 1 cycle after their event.
- Per-context registers: state {IDLE, RECV, DROP}, exp_seq (LEN_W), remain (LEN_W), timer (TMR_W).
- IDLE:
  - hit with seq_in==0 and 1<=length_in<=LEN_MAX: valid, sop.
    - length_in==1: eop, stay IDLE.
    - otherwise: exp_seq=1, remain=length_in-1, go to RECV.
  - hit with seq_in!=0, length_in==0, or length_in>LEN_MAX: drop_out, stay IDLE.
- RECV:
  - hit with seq_in==exp_seq: valid; exp_seq+1; remain-1; timer=0. When remain==1 before the decrement: eop, go to IDLE.
  - hit with seq mismatch: drop_out, go to DROP.
  - no hit to this context: timer+1. When timer reaches TIMEOUT: timeout_out, go to IDLE.
- DROP:
  - Subsequent hits are discarded silently (no extra drop_out).
  - A hit with seq_in==0 and valid length starts a new packet exactly as in IDLE (same cycle).
  - The timer runs as in RECV; on expiry go to IDLE with no timeout_out pulse.
- Simultaneous events:
  - Hit and timer expiry on the same context in the same cycle: the hit wins and the timer clears.
  - flush_in with a hit: flush wins; the cell is dropped and no drop_out is raised.
  - drop_out and timeout_out from different contexts in the same cycle: both pulse; err_cnt increments by 2.
- err_cnt saturates at 16'hFFFF.
- Arithmetic: all counters are modulo their width but never wrap in legal use; remain is never decremented below 1.

Test Plan:
- Single packet: ctx0, length 4, seq 0..3 back-to-back -> valid 4 cycles; sop on cycle 1, eop on cycle 4; busy_out[0] high for 3 cycles; err_cnt 0.
- Interleave: ctx0 length 3 and ctx1 length 2, cells alternating 0:0,1:0,0:1,1:1,0:2 -> 5 valids; eop on 1:1 and 0:2; no drops.
- Out-of-order: ctx0 length 5, seq 0,1,3,4 -> valids for 0,1; one drop_out at seq 3; seq 4 silent; a new seq 0 length 1 restarts -> sop+eop; err_cnt 1.
- Timeout (TIMEOUT=8): ctx1 length 3, seq 0 then 8 idle cycles -> timeout_out once; busy_out[1] returns to 0; seq 1 arriving later -> drop_out (orphan); err_cnt 2.
- Filtering/edge: tx_in!=PORT_ID cells ignored; length_in==0 at seq 0 -> drop_out; length 1 -> sop and eop same cycle.
- flush_in mid-packet plus hit in the same cycle -> no valid, no drop_out; all busy_out 0 next cycle; async reset mid-packet -> all outputs 0 immediately.
